// File: rtl/b2g_counter.sv
// b2g_counter: registered binary counter with a registered Gray-coded image.
// Supports up/down counting, parallel load, and either wrap-around or
// saturation at the ends. The Gray register is loaded from the next binary
// value, so both outputs change on the same edge and always agree.
module b2g_counter #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Gray image of a binary word: adjacent values differ in exactly one bit.
    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] next_bin_s;
    logic             next_wrap_s;
    logic             at_max_s;
    logic             at_zero_s;

    assign at_max_s  = (binary == MAX_VAL);
    assign at_zero_s = (binary == ZERO_VAL);

    // Terminal count follows the live direction input, not a registered copy.
    assign tc = up ? at_max_s : at_zero_s;

    // Next-count selection: load beats counting; ends either wrap or hold.
    always_comb begin
        next_bin_s  = binary;
        next_wrap_s = 1'b0;
        if (load) begin
            next_bin_s  = load_bin;
            next_wrap_s = 1'b0;
        end else if (en) begin
            if (up) begin
                if (!at_max_s) begin
                    next_bin_s  = binary + ONE_VAL;
                    next_wrap_s = 1'b0;
                end else if (SATURATE) begin
                    next_bin_s  = binary;
                    next_wrap_s = 1'b0;
                end else begin
                    next_bin_s  = ZERO_VAL;
                    next_wrap_s = 1'b1;
                end
            end else begin
                if (!at_zero_s) begin
                    next_bin_s  = binary - ONE_VAL;
                    next_wrap_s = 1'b0;
                end else if (SATURATE) begin
                    next_bin_s  = binary;
                    next_wrap_s = 1'b0;
                end else begin
                    next_bin_s  = MAX_VAL;
                    next_wrap_s = 1'b1;
                end
            end
        end else begin
            next_bin_s  = binary;
            next_wrap_s = 1'b0;
        end
    end

    // State registers: Gray is encoded from the next binary value, never from binary.
    always_ff @(posedge clk) begin
        if (rst) begin
            binary <= ZERO_VAL;
            gray   <= ZERO_VAL;
            wrap   <= 1'b0;
        end else begin
            binary <= next_bin_s;
            gray   <= bin_to_gray(next_bin_s);
            wrap   <= next_wrap_s;
        end
    end

endmodule

// File: tb/tb_b2g_counter.sv
// Directed testbench for b2g_counter: a wrap-mode and a saturate-mode
// instance share one stimulus; each task checks its own expected values.
module tb_b2g_counter;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_bin;
    logic [W-1:0] binary;
    logic [W-1:0] gray;
    logic         tc;
    logic         wrap;
    logic [W-1:0] s_binary;
    logic [W-1:0] s_gray;
    logic         s_tc;
    logic         s_wrap;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_up_gray [16] = '{
        4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
        4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000
    };

    b2g_counter #(.WIDTH(W), .SATURATE(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
        .binary(binary), .gray(gray), .tc(tc), .wrap(wrap)
    );

    b2g_counter #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
        .binary(s_binary), .gray(s_gray), .tc(s_tc), .wrap(s_wrap)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // XOR-prefix decode of a Gray word back to binary.
    function automatic logic [W-1:0] gray_decode(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Advance one clock edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b1; up = 1'b0; load_bin = 4'b1010;
        tick();
        tick();
        checks++;
        if (binary !== 4'b0000 || gray !== 4'b0000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset: got bin=%b gray=%b wrap=%b, expected 0000 0000 0", binary, gray, wrap);
        end
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL reset_tc_down: got %b expected 1", tc);
        end
        up = 1'b1;
        #1;
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_tc_up: got %b expected 0", tc);
        end
    endtask

    task automatic test_up_sweep();
        logic [W-1:0] prev_gray;
        logic [W-1:0] exp_bin;
        rst = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
        prev_gray = gray;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_bin = W'(i + 1);
            checks++;
            if (gray !== exp_up_gray[i] || binary !== exp_bin) begin
                errors++;
                $display("FAIL up_sweep step %0d: got bin=%b gray=%b, expected %b %b", i, binary, gray, exp_bin, exp_up_gray[i]);
            end
            checks++;
            if ($countones(gray ^ prev_gray) != 1) begin
                errors++;
                $display("FAIL up_sweep_hamming step %0d: got %b -> %b, expected one bit change", i, prev_gray, gray);
            end
            checks++;
            if (wrap !== (i == 15)) begin
                errors++;
                $display("FAIL up_sweep_wrap step %0d: got %b expected %b", i, wrap, (i == 15));
            end
            prev_gray = gray;
        end
        checks++;
        if (s_binary !== 4'b1111 || s_wrap !== 1'b0) begin
            errors++;
            $display("FAIL sat_sweep_end: got bin=%b wrap=%b, expected 1111 0", s_binary, s_wrap);
        end
        en = 1'b0;
        tick();
        checks++;
        if (wrap !== 1'b0 || binary !== 4'b0000 || gray !== 4'b0000) begin
            errors++;
            $display("FAIL hold_after_wrap: got bin=%b gray=%b wrap=%b, expected 0000 0000 0", binary, gray, wrap);
        end
    endtask

    task automatic test_load();
        load = 1'b1; en = 1'b1; up = 1'b1; load_bin = 4'b1011;
        tick();
        load = 1'b0; en = 1'b0;
        checks++;
        if (binary !== 4'b1011 || gray !== 4'b1110 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load: got bin=%b gray=%b wrap=%b, expected 1011 1110 0", binary, gray, wrap);
        end
    endtask

    task automatic test_down_wrap();
        load = 1'b1; load_bin = 4'b0000; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        checks++;
        if (binary !== 4'b1111 || gray !== 4'b1000 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap: got bin=%b gray=%b wrap=%b, expected 1111 1000 1", binary, gray, wrap);
        end
        checks++;
        if (s_binary !== 4'b0000 || s_gray !== 4'b0000 || s_wrap !== 1'b0 || s_tc !== 1'b1) begin
            errors++;
            $display("FAIL sat_down_hold: got bin=%b gray=%b wrap=%b tc=%b, expected 0000 0000 0 1", s_binary, s_gray, s_wrap, s_tc);
        end
        tick();
        checks++;
        if (binary !== 4'b1110 || gray !== 4'b1001 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL down_step: got bin=%b gray=%b wrap=%b, expected 1110 1001 0", binary, gray, wrap);
        end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        load = 1'b1; load_bin = 4'b1100; en = 1'b0; up = 1'b1;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (s_binary !== 4'b1111 || s_gray !== 4'b1000) begin
            errors++;
            $display("FAIL sat_reach_max: got bin=%b gray=%b, expected 1111 1000", s_binary, s_gray);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (s_binary !== 4'b1111 || s_gray !== 4'b1000 || s_tc !== 1'b1 || s_wrap !== 1'b0) begin
                errors++;
                $display("FAIL sat_hold cycle %0d: got bin=%b gray=%b tc=%b wrap=%b, expected 1111 1000 1 0", i, s_binary, s_gray, s_tc, s_wrap);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid();
        load = 1'b1; load_bin = 4'b0000; en = 1'b0; up = 1'b1;
        tick();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (gray_decode(gray) !== binary || binary !== W'(i + 1)) begin
                errors++;
                $display("FAIL mid_decode step %0d: got bin=%b gray=%b, expected bin %0d", i, binary, gray, i + 1);
            end
        end
        rst = 1'b1; load = 1'b1; load_bin = 4'b1010;
        tick();
        checks++;
        if (binary !== 4'b0000 || gray !== 4'b0000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got bin=%b gray=%b wrap=%b, expected 0000 0000 0", binary, gray, wrap);
        end
        rst = 1'b0; load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (binary !== W'(i + 1) || gray_decode(gray) !== binary) begin
                errors++;
                $display("FAIL resume step %0d: got bin=%b gray=%b, expected bin %0d", i, binary, gray, i + 1);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        load = 1'b1; load_bin = 4'b0101; en = 1'b0; up = 1'b1;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        checks++;
        if (binary !== 4'b0110 || gray !== 4'b0101) begin
            errors++;
            $display("FAIL dir_up: got bin=%b gray=%b, expected 0110 0101", binary, gray);
        end
        up = 1'b0;
        tick();
        checks++;
        if (binary !== 4'b0101 || gray !== 4'b0111) begin
            errors++;
            $display("FAIL dir_down: got bin=%b gray=%b, expected 0101 0111", binary, gray);
        end
        en = 1'b0;
        tick();
        tick();
        checks++;
        if (binary !== 4'b0101 || gray !== 4'b0111 || wrap !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL hold: got bin=%b gray=%b wrap=%b tc=%b, expected 0101 0111 0 0", binary, gray, wrap, tc);
        end
    endtask

    // Test sequence.
    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_bin = 4'b0000;
        test_reset();
        test_up_sweep();
        test_load();
        test_down_wrap();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
